// File: rtl/perceptron_pkg.sv
// Shared widths, config address map and FSM state encoding for the
// sequential perceptron controller.
package perceptron_pkg;

  localparam int N_INPUTS = 4;
  localparam int DATA_W   = 8;
  localparam int ACC_W    = 20;
  localparam int ADDR_W   = $clog2(N_INPUTS + 2);
  localparam int IDX_W    = $clog2(N_INPUTS);

  localparam logic [ADDR_W-1:0] CFG_BIAS   = ADDR_W'(N_INPUTS);
  localparam logic [ADDR_W-1:0] CFG_THRESH = ADDR_W'(N_INPUTS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    ACT  = 2'd2,
    OUT  = 2'd3
  } state_t;

  // Clamp an accumulator value into the result width.
  function automatic logic [DATA_W-1:0] saturate(input logic [ACC_W-1:0] acc);
    if (acc > ACC_W'((1 << DATA_W) - 1)) begin
      return '1;
    end
    return acc[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/perceptron_mac_unit.sv
// Single multiply-accumulate slice: one DATA_W x DATA_W multiplier feeding a
// registered accumulator that can be preloaded with the bias.
module perceptron_mac_unit
  import perceptron_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [DATA_W-1:0] bias,
  input  logic              acc_en,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] w,
  output logic [ACC_W-1:0]  acc
);

  logic [2*DATA_W-1:0] prod;

  assign prod = x * w;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= ACC_W'(bias);
    end else if (acc_en) begin
      acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/perceptron_seq_ctrl.sv
// Sequential 4-input perceptron: config regfile, input latch, scheduling FSM
// and threshold/saturating activation around a shared MAC slice.
module perceptron_seq_ctrl
  import perceptron_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_we,
  input  logic [ADDR_W-1:0]            cfg_addr,
  input  logic [DATA_W-1:0]            cfg_data,
  output logic                         cfg_ready,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_INPUTS*DATA_W-1:0]   in_x,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_active,
  output logic [1:0]                   dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; a source holds valid and its payload steady until that edge,
  // and ready never depends combinationally on valid.

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic [N_INPUTS*DATA_W-1:0] x_lat;
  logic [DATA_W-1:0]        w_reg [N_INPUTS];
  logic [DATA_W-1:0]        w_lat [N_INPUTS];
  logic [DATA_W-1:0]        bias_reg;
  logic [DATA_W-1:0]        thresh_reg;
  logic [DATA_W-1:0]        thresh_lat;
  logic [ACC_W-1:0]         acc;
  logic [DATA_W-1:0]        x_sel;
  logic [DATA_W-1:0]        w_sel;
  logic                     accept;
  logic                     cfg_wr;

  assign in_ready  = (state == IDLE) && !rst;
  assign cfg_ready = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign cfg_wr    = cfg_we && cfg_ready;
  assign dbg_state = state;
  assign x_sel     = x_lat[int'(idx)*DATA_W +: DATA_W];
  assign w_sel     = w_lat[idx];

  // Bias is read live at accept; the non-blocking update means a write in the
  // same cycle is not seen by that sample.
  perceptron_mac_unit u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .bias   (bias_reg),
    .acc_en (state == MAC),
    .x      (x_sel),
    .w      (w_sel),
    .acc    (acc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_INPUTS; k++) w_reg[k] <= '0;
      bias_reg   <= '0;
      thresh_reg <= '0;
    end else if (cfg_wr) begin
      if (cfg_addr < ADDR_W'(N_INPUTS)) begin
        w_reg[cfg_addr[IDX_W-1:0]] <= cfg_data;
      end else if (cfg_addr == CFG_BIAS) begin
        bias_reg <= cfg_data;
      end else if (cfg_addr == CFG_THRESH) begin
        thresh_reg <= cfg_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      x_lat      <= '0;
      thresh_lat <= '0;
      for (int k = 0; k < N_INPUTS; k++) w_lat[k] <= '0;
      out_data   <= '0;
      out_active <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            // Snapshot coefficients so a coincident config write waits for the next sample.
            x_lat      <= in_x;
            thresh_lat <= thresh_reg;
            for (int k = 0; k < N_INPUTS; k++) w_lat[k] <= w_reg[k];
            idx        <= '0;
            state      <= MAC;
          end
        end
        MAC: begin
          idx <= idx + 1'b1;
          if (idx == IDX_W'(N_INPUTS - 1)) begin
            state <= ACT;
          end
        end
        ACT: begin
          if (acc < ACC_W'(thresh_lat)) begin
            out_data   <= '0;
            out_active <= 1'b0;
          end else begin
            out_data   <= saturate(acc);
            out_active <= 1'b1;
          end
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_seq_ctrl.sv
// Directed bench for perceptron_seq_ctrl: hand-computed vectors, an expected
// result queue, and a single compare task feeding the final summary.
module tb_perceptron_seq_ctrl;
  import perceptron_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       cfg_we;
  logic [ADDR_W-1:0]          cfg_addr;
  logic [DATA_W-1:0]          cfg_data;
  logic                       cfg_ready;
  logic                       in_valid;
  logic                       in_ready;
  logic [N_INPUTS*DATA_W-1:0] in_x;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_W-1:0]          out_data;
  logic                       out_active;
  logic [1:0]                 dbg_state;

  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [DATA_W:0] exp_q[$];

  perceptron_seq_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .cfg_ready  (cfg_ready),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_active (out_active),
    .dbg_state  (dbg_state)
  );

  // Clock / reset / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic cfg_all(input logic [DATA_W-1:0] w0, w1, w2, w3, b, t);
    cfg_write(3'd0, w0);
    cfg_write(3'd1, w1);
    cfg_write(3'd2, w2);
    cfg_write(3'd3, w3);
    cfg_write(CFG_BIAS, b);
    cfg_write(CFG_THRESH, t);
  endtask

  // Drives a sample and returns just after the accepting edge.
  task automatic send_sample(input logic [N_INPUTS*DATA_W-1:0] x);
    int n = 0;
    in_x     = x;
    in_valid = 1'b1;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    check("accept_wait", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  // Latency check, scoreboard compare and output handshake (out_ready high).
  task automatic finish_sample(input string tag);
    logic [DATA_W:0] e;
    while (cyc < acc_cyc + 4) step();
    check({tag, "_lat_lo"}, 32'(out_valid), 32'd0);
    step();
    check({tag, "_lat_hi"}, 32'(out_valid), 32'd1);
    e = exp_q.pop_front();
    check({tag, "_data"}, 32'(out_data), 32'(e[DATA_W-1:0]));
    check({tag, "_active"}, 32'(out_active), 32'(e[DATA_W]));
    step();
    check({tag, "_drop"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_sample(input string tag, input logic [N_INPUTS*DATA_W-1:0] x,
                            input logic [DATA_W-1:0] d, input logic act);
    exp_q.push_back({act, d});
    send_sample(x);
    finish_sample(tag);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; in_x = '0; out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("post_rst_state", 32'(dbg_state), 32'(IDLE));
    check("post_rst_active", 32'(out_active), 32'd0);
    step();

    // Basic fire / no fire around threshold 20
    cfg_all(8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 8'd20);
    run_sample("fire",    32'h01010101, 8'd20, 1'b1);
    run_sample("nofire",  32'h00000000, 8'd0,  1'b0);
    run_sample("below",   32'h01000002, 8'd0,  1'b0);
    run_sample("fire40",  32'h03030303, 8'd40, 1'b1);
    run_sample("fire_x3", 32'h05000000, 8'd30, 1'b1);

    // Saturation
    cfg_all(8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0);
    run_sample("sat_max",  32'hFFFFFFFF, 8'hFF, 1'b1);
    run_sample("sat_edge", 32'h00000000, 8'hFF, 1'b1);
    run_sample("sat_510",  32'h00000001, 8'hFF, 1'b1);

    // Backpressure with a second sample pending
    cfg_all(8'd1, 8'd2, 8'd3, 8'd4, 8'd10, 8'd20);
    out_ready = 1'b0;
    exp_q.push_back({1'b1, 8'd20});
    send_sample(32'h01010101);
    while (cyc < acc_cyc + 5) step();
    begin
      logic [DATA_W:0] e;
      e = exp_q.pop_front();
      check("bp_a_valid", 32'(out_valid), 32'd1);
      check("bp_a_data", 32'(out_data), 32'(e[DATA_W-1:0]));
    end
    in_x     = 32'h03030303;
    in_valid = 1'b1;
    exp_q.push_back({1'b1, 8'd40});
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_data", 32'(out_data), 32'd20);
      check("bp_hold_active", 32'(out_active), 32'd1);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp_hs_valid", 32'(out_valid), 32'd0);
    check("bp_hs_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    acc_cyc  = cyc;
    check("bp_b_state", 32'(dbg_state), 32'(MAC));
    finish_sample("bp_b");

    // Config write while busy is dropped
    exp_q.push_back({1'b1, 8'd20});
    send_sample(32'h01010101);
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 8'd99;
    check("busy_cfg_ready", 32'(cfg_ready), 32'd0);
    step();
    cfg_we = 1'b0;
    finish_sample("busy");
    run_sample("after_busy", 32'h01010101, 8'd20, 1'b1);

    // Write coincident with accept: sample sees old w0, next sample new w0
    exp_q.push_back({1'b0, 8'd0});
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 8'd7;
    send_sample(32'h00000005);
    cfg_we = 1'b0;
    finish_sample("same_cyc");
    run_sample("new_w0", 32'h00000005, 8'd45, 1'b1);

    // Ignored out-of-range address
    cfg_write(3'd7, 8'd200);
    run_sample("bad_addr", 32'h00000005, 8'd45, 1'b1);

    // Reset in MAC at idx 2
    send_sample(32'h01010101);
    step();
    step();
    check("mid_state", 32'(dbg_state), 32'(MAC));
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("mid_out_valid", 32'(out_valid), 32'd0);
    check("mid_state_idle", 32'(dbg_state), 32'(IDLE));
    check("mid_in_ready", 32'(in_ready), 32'd1);
    run_sample("post_mid", 32'h05050505, 8'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
